// File: rtl/text_screen_ctrl.sv
// text_screen_ctrl
//   Character-screen controller sitting in front of the ascii_font engine.
//   Holds a COLS x ROWS buffer of 8-bit character codes, accepts writes from
//   two round-robin arbitrated producers (A, B), performs full-buffer clears
//   to 0x20, and during video picks one bit of char_data as the output pixel.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   blank                 video blanking (same timing as char_x/char_y)
//   char_x, char_y        character cell currently being scanned
//   char_data             per-code pixel bits, one cycle after char_x/char_y
//   a_valid/a_ready       producer A handshake, a_x/a_y/a_code payload
//   b_valid/b_ready       producer B handshake, b_x/b_y/b_code payload
//   clear                 one-cycle pulse, fills buffer with 0x20
//   busy                  high while a clear is running
//   drop                  sticky: an out-of-range write was accepted
//   pixel, pixel_blank    glyph pixel and blank, both 2 cycles after inputs
module text_screen_ctrl #(
  parameter int COLS = 64,
  parameter int ROWS = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         blank,
  input  logic [7:0]   char_x,
  input  logic [7:0]   char_y,
  input  logic [255:0] char_data,
  input  logic         a_valid,
  output logic         a_ready,
  input  logic [7:0]   a_x,
  input  logic [7:0]   a_y,
  input  logic [7:0]   a_code,
  input  logic         b_valid,
  output logic         b_ready,
  input  logic [7:0]   b_x,
  input  logic [7:0]   b_y,
  input  logic [7:0]   b_code,
  input  logic         clear,
  output logic         busy,
  output logic         drop,
  output logic         pixel,
  output logic         pixel_blank
);

  localparam int XW    = $clog2(COLS);
  localparam int YW    = $clog2(ROWS);
  localparam int AW    = XW + YW;
  localparam int DEPTH = COLS * ROWS;

  // 9-bit limits so COLS = 256 still compares correctly against 8-bit x.
  localparam logic [8:0] COLS_LIM = 9'(COLS);
  localparam logic [8:0] ROWS_LIM = 9'(ROWS);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  localparam logic RR_A = 1'b0;
  localparam logic RR_B = 1'b1;

  logic [0:0]    state_reg;
  logic [AW-1:0] clr_addr_reg;
  logic          rr_last_reg;
  logic          drop_reg;

  logic [7:0]    mem [DEPTH];
  logic [7:0]    rd_data_reg;
  logic          disp_oob_reg;
  logic          blank_d1_reg;
  logic          pixel_reg;
  logic          pixel_blank_reg;

  logic          a_in_range, b_in_range, disp_in_range;
  logic [AW-1:0] a_addr, b_addr, disp_addr;
  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;
  logic [7:0]    code;

  // Range checks use the full 8-bit coordinates; addresses use only the
  // low bits, which is safe because out-of-range writes never reach memory.
  assign a_in_range    = ({1'b0, a_x} < COLS_LIM) && ({1'b0, a_y} < ROWS_LIM);
  assign b_in_range    = ({1'b0, b_x} < COLS_LIM) && ({1'b0, b_y} < ROWS_LIM);
  assign disp_in_range = ({1'b0, char_x} < COLS_LIM) && ({1'b0, char_y} < ROWS_LIM);
  assign a_addr        = {a_y[YW-1:0], a_x[XW-1:0]};
  assign b_addr        = {b_y[YW-1:0], b_x[XW-1:0]};
  assign disp_addr     = {char_y[YW-1:0], char_x[XW-1:0]};

  // Round-robin: on a tie the requester that did not win last time goes.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (state_reg == ST_IDLE) begin
      if (a_valid && (!b_valid || rr_last_reg == RR_B)) begin
        a_ready = 1'b1;
      end else if (b_valid) begin
        b_ready = 1'b1;
      end
    end
  end

  // Single write port shared by the clear sequencer and the two producers.
  always_comb begin
    we    = 1'b0;
    waddr = clr_addr_reg;
    wdata = 8'h20;
    if (state_reg == ST_CLEAR) begin
      we = 1'b1;
    end else if (a_ready && a_in_range) begin
      we    = 1'b1;
      waddr = a_addr;
      wdata = a_code;
    end else if (b_ready && b_in_range) begin
      we    = 1'b1;
      waddr = b_addr;
      wdata = b_code;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_CLEAR;
      clr_addr_reg <= '0;
      rr_last_reg  <= RR_B;
      drop_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ST_CLEAR: begin
          clr_addr_reg <= clr_addr_reg + AW'(1);
          if (clr_addr_reg == LAST_ADDR) begin
            state_reg <= ST_IDLE;
          end
        end
        default: begin
          if (a_ready) begin
            rr_last_reg <= RR_A;
            if (!a_in_range) drop_reg <= 1'b1;
          end
          if (b_ready) begin
            rr_last_reg <= RR_B;
            if (!b_in_range) drop_reg <= 1'b1;
          end
          // The transfer above still commits; the clear overwrites it later.
          if (clear) begin
            state_reg    <= ST_CLEAR;
            clr_addr_reg <= '0;
          end
        end
      endcase
    end
  end

  // Buffer: no reset so it maps onto block RAM; read-before-write ordering
  // means a same-cycle read of a written address returns the old code.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rd_data_reg <= mem[disp_addr];
  end

  assign code = disp_oob_reg ? 8'h20 : rd_data_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_oob_reg    <= 1'b0;
      blank_d1_reg    <= 1'b1;
      pixel_reg       <= 1'b0;
      pixel_blank_reg <= 1'b1;
    end else begin
      disp_oob_reg    <= !disp_in_range;
      blank_d1_reg    <= blank;
      pixel_reg       <= char_data[code] & ~blank_d1_reg;
      pixel_blank_reg <= blank_d1_reg;
    end
  end

  assign busy        = (state_reg == ST_CLEAR);
  assign drop        = drop_reg;
  assign pixel       = pixel_reg;
  assign pixel_blank = pixel_blank_reg;

endmodule

// File: tb/tb_text_screen_ctrl.sv
// Scoreboard bench for text_screen_ctrl: stimulus pushes expected grants and
// expected pixel/pixel_blank pairs; a negedge monitor pops and compares.
module tb_text_screen_ctrl;

  localparam int COLS = 64;
  localparam int ROWS = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         blank;
  logic [7:0]   char_x, char_y;
  logic [255:0] char_data;
  logic         a_valid, a_ready;
  logic [7:0]   a_x, a_y, a_code;
  logic         b_valid, b_ready;
  logic [7:0]   b_x, b_y, b_code;
  logic         clear;
  logic         busy, drop, pixel, pixel_blank;

  text_screen_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .reset(reset), .blank(blank),
    .char_x(char_x), .char_y(char_y), .char_data(char_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_x(a_x), .a_y(a_y), .a_code(a_code),
    .b_valid(b_valid), .b_ready(b_ready), .b_x(b_x), .b_y(b_y), .b_code(b_code),
    .clear(clear), .busy(busy), .drop(drop),
    .pixel(pixel), .pixel_blank(pixel_blank)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  bit         grant_q[$];   // 0 = A, 1 = B
  logic [1:0] pix_q[$];     // {pixel, pixel_blank}
  logic       probe;
  logic       probe_d1, probe_d2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      probe_d1 <= 1'b0;
      probe_d2 <= 1'b0;
    end else begin
      probe_d1 <= probe;
      probe_d2 <= probe_d1;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (a_ready || b_ready) begin
        check("one_ready", {31'd0, a_ready && b_ready}, 0);
        if (grant_q.size() == 0) begin
          check("unexpected_grant", {30'd0, a_ready, b_ready}, 0);
        end else begin
          check("grant_b", {31'd0, b_ready}, {31'd0, grant_q.pop_front()});
        end
      end
      if (probe_d2) begin
        if (pix_q.size() == 0) begin
          check("pixel_queue_empty", 1, 0);
        end else begin
          check("pixel_pair", {30'd0, pixel, pixel_blank}, {30'd0, pix_q.pop_front()});
        end
      end
    end
  end

  function automatic logic [255:0] onehot(input logic [7:0] c);
    logic [255:0] v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated lookup: coordinates now, char_data one cycle later.
  task automatic probe_cell(input int x, input int y, input logic bl,
                            input logic [255:0] cd, input logic exp_pix, input logic exp_pb);
    char_x = x[7:0];
    char_y = y[7:0];
    blank  = bl;
    probe  = 1'b1;
    pix_q.push_back({exp_pix, exp_pb});
    tick();
    probe     = 1'b0;
    char_data = cd;
    tick();
    tick();
  endtask

  task automatic do_write(input bit who, input int x, input int y, input logic [7:0] c);
    int w;
    w = 0;
    if (!who) begin
      a_valid = 1'b1; a_x = x[7:0]; a_y = y[7:0]; a_code = c;
    end else begin
      b_valid = 1'b1; b_x = x[7:0]; b_y = y[7:0]; b_code = c;
    end
    grant_q.push_back(who);
    forever begin
      @(negedge clk);
      if (who ? b_ready : a_ready) break;
      w++;
      if (w > 100) break;
    end
    check("grant_latency", w, 0);
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
    $display("write %s (%0d,%0d) code=%02h", who ? "B" : "A", x, y, c);
  endtask

  // Counts rising edges until busy is seen low; pulses clear after edge pulse_at.
  task automatic run_clear(input int pulse_at, output int n);
    n = 0;
    for (int k = 0; k < 5000; k++) begin
      @(posedge clk);
      n++;
      #1 clear = (n == pulse_at);
      @(negedge clk);
      if (!busy) break;
    end
    clear = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [4:0] glyph_row;

    reset = 1'b1; blank = 1'b1; char_x = 0; char_y = 0; char_data = '0;
    a_valid = 0; a_x = 0; a_y = 0; a_code = 0;
    b_valid = 0; b_x = 0; b_y = 0; b_code = 0;
    clear = 0; probe = 0;
    repeat (3) tick();
    check("rst_busy", {31'd0, busy}, 1);
    check("rst_a_ready", {31'd0, a_ready}, 0);
    check("rst_b_ready", {31'd0, b_ready}, 0);
    check("rst_drop", {31'd0, drop}, 0);
    check("rst_pixel", {31'd0, pixel}, 0);
    check("rst_pixel_blank", {31'd0, pixel_blank}, 1);

    // Automatic clear after reset; A waits with a harmless write the whole time.
    reset = 1'b0;
    a_valid = 1'b1; a_x = 5; a_y = 5; a_code = 8'h20;
    grant_q.push_back(1'b0);
    run_clear(0, n);
    check("reset_clear_cycles", n, 2048);
    check("ready_when_busy_falls", {31'd0, a_ready}, 1);
    tick();
    a_valid = 1'b0;
    $display("write A (5,5) code=20");

    // Full-frame scan: every cell must hold 0x20.
    blank = 1'b0;
    char_data = onehot(8'h20);
    tick();
    for (int y = 0; y < ROWS; y++) begin
      for (int x = 0; x < COLS; x++) begin
        char_x = x[7:0];
        char_y = y[7:0];
        probe  = 1'b1;
        pix_q.push_back(2'b10);
        tick();
      end
    end
    probe = 1'b0;
    repeat (3) tick();
    probe_cell(70, 40, 1'b0, onehot(8'h20), 1'b1, 1'b0);  // off-screen -> 0x20

    // 'A' at (0,0), then glyph row 1 = 01110 across columns 0-4.
    do_write(1'b0, 0, 0, 8'h41);
    probe_cell(0, 0, 1'b0, onehot(8'h41), 1'b1, 1'b0);
    glyph_row = 5'b01110;
    for (int c = 0; c < 5; c++) begin
      logic [255:0] cd;
      cd = '0;
      cd[8'h41] = glyph_row[4-c];
      probe_cell(0, 0, 1'b0, cd, glyph_row[4-c], 1'b0);
    end
    probe_cell(0, 0, 1'b1, onehot(8'h41), 1'b0, 1'b1);      // blanked

    // Make B the last winner, then a four-cycle tie: A, B, A, B.
    do_write(1'b1, 9, 9, 8'h39);
    a_valid = 1'b1; a_x = 1; a_y = 1; a_code = 8'h31;
    b_valid = 1'b1; b_x = 2; b_y = 2; b_code = 8'h32;
    grant_q.push_back(1'b0); grant_q.push_back(1'b1);
    grant_q.push_back(1'b0); grant_q.push_back(1'b1);
    repeat (4) @(posedge clk);
    #1 a_valid = 1'b0; b_valid = 1'b0;
    $display("tie A(1,1)=31 / B(2,2)=32 for 4 cycles");
    tick();
    check("tie_grants_consumed", grant_q.size(), 0);
    probe_cell(1, 1, 1'b0, onehot(8'h31), 1'b1, 1'b0);
    probe_cell(2, 2, 1'b0, onehot(8'h32), 1'b1, 1'b0);
    probe_cell(9, 9, 1'b0, onehot(8'h39), 1'b1, 1'b0);

    // Out-of-range writes: handshaked, discarded, drop sticks.
    check("drop_before_oor", {31'd0, drop}, 0);
    do_write(1'b0, 64, 0, 8'h55);
    do_write(1'b1, 0, 32, 8'h55);
    check("drop_after_oor", {31'd0, drop}, 1);
    probe_cell(0, 0, 1'b0, onehot(8'h41), 1'b1, 1'b0);      // aliases of (0,0) untouched

    // clear together with a B transfer; a second clear mid-sequence is ignored.
    b_valid = 1'b1; b_x = 3; b_y = 3; b_code = 8'h5A; clear = 1'b1;
    grant_q.push_back(1'b1);
    @(negedge clk);
    check("b_ready_with_clear", {31'd0, b_ready}, 1);
    tick();
    b_valid = 1'b0; clear = 1'b0;
    $display("write B (3,3) code=5a with clear");
    run_clear(100, n);
    check("clear_cycles_with_reclear", n, 2048);
    probe_cell(3, 3, 1'b0, onehot(8'h20), 1'b1, 1'b0);
    probe_cell(3, 3, 1'b0, onehot(8'h5A), 1'b0, 1'b0);
    check("drop_still_set", {31'd0, drop}, 1);

    // Reset at clear cycle 500.
    char_data = '1; blank = 1'b0; clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (500) @(posedge clk);
    #1;
    check("pre_reset_pixel", {31'd0, pixel}, 1);
    check("pre_reset_pixel_blank", {31'd0, pixel_blank}, 0);
    check("pre_reset_busy", {31'd0, busy}, 1);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 1);
    check("mid_rst_a_ready", {31'd0, a_ready}, 0);
    check("mid_rst_b_ready", {31'd0, b_ready}, 0);
    check("mid_rst_drop", {31'd0, drop}, 0);
    check("mid_rst_pixel", {31'd0, pixel}, 0);
    check("mid_rst_pixel_blank", {31'd0, pixel_blank}, 1);
    tick();
    reset = 1'b0;
    run_clear(0, n);
    check("restart_clear_cycles", n, 2048);
    probe_cell(0, 0, 1'b0, onehot(8'h20), 1'b1, 1'b0);
    check("pix_queue_drained", pix_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/text_screen_ctrl.md
# text_screen_ctrl

Character-screen controller in front of `ascii_font`. It owns an 8-bit character-code buffer and arbitrates write requests from two producers (A, B) with round-robin fairness. It sequences buffer clears and, during active video, looks up the code at the font engine's `char_x`/`char_y` to pick one bit of the 256-bit `char_data` vector as the output pixel.

## Interface
- `COLS`, default 64: screen columns, power of two, at most 256.
- `ROWS`, default 32: screen rows, power of two, at most 64.
- `clk` in 1: sole clock.
- `reset` in 1: reset, asynchronous, active-high.
- `blank` in 1: video blanking, same timing as the font engine input.
- `char_x` in 8: character column from `ascii_font`.
- `char_y` in 8: character row from `ascii_font`.
- `char_data` in 256: per-ASCII-code pixel bits from `ascii_font`.
- `a_valid` in 1: requester A write request.
- `a_ready` out 1: requester A grant.
- `a_x` in 8: requester A target column.
- `a_y` in 8: requester A target row.
- `a_code` in 8: requester A ASCII code.
- `b_valid` in 1: requester B write request.
- `b_ready` out 1: requester B grant.
- `b_x` in 8: requester B target column.
- `b_y` in 8: requester B target row.
- `b_code` in 8: requester B ASCII code.
- `clear` in 1: single-cycle pulse; fills the buffer with 0x20.
- `busy` out 1: high while a clear is in progress.
- `drop` out 1: sticky; an out-of-range write was accepted and discarded. Cleared only by reset.
- `pixel` out 1: glyph pixel.
- `pixel_blank` out 1: `blank` delayed to align with `pixel`.

## Operation
- Buffer: COLS*ROWS x 8 bits, address = y*COLS + x. One write port, one synchronous read port. Not reset; contents are made defined by the clear sequence.
- FSM states:
  - CLEAR: writes 0x20 at `clr_addr`, then increments `clr_addr`. After writing address COLS*ROWS-1, goes to IDLE. `busy`=1 and both readies are 0 throughout.
  - IDLE: arbitrates writes. A `clear` pulse moves the FSM to CLEAR with `clr_addr`=0.
- Reset enters CLEAR with `clr_addr`=0, so every reset performs an automatic full clear.
- Arbitration (IDLE only, combinational ready):
  - Only one requester valid: that requester gets ready.
  - Both valid: grant goes to the requester not granted last.
  - `rr_last` updates on each transfer (`valid && ready`).
  - Reset value of `rr_last` is B, so A wins the first tie.
- Handshake rules:
  - A requester holds valid, x, y and code stable until ready.
  - One write is committed per cycle.
  - At most one ready is high per cycle.
- Out-of-range writes (x >= COLS or y >= ROWS) are still handshaked. The buffer is not written and `drop` sets.
- `clear` in the same cycle as a transfer: the transfer commits, then CLEAR starts on the next cycle and overwrites it.
- `clear` while already in CLEAR is ignored and does not restart the sequence.
- Display path:
  - Stage 1: read the buffer at (`char_x`, `char_y`). Coordinates outside COLS/ROWS substitute code 0x20.
  - Stage 2: `pixel` <= `char_data[code_q]` & ~`blank_d1`.
  - `blank` goes through a matching two-flop delay to produce `pixel_blank`.
- Any code with no glyph entry yields 0 because `char_data` is 0 for it.
- The display read continues during CLEAR and may show a partly cleared buffer.

## Timing
- Reset values: `a_ready`=0, `b_ready`=0, `busy`=1, `drop`=0, `pixel`=0, `pixel_blank`=1, `clr_addr`=0, `rr_last`=B.
- A clear takes exactly COLS*ROWS cycles (2048 at default parameters). `busy` falls on the cycle after the last clear write, and readies can assert in that same cycle.
- A write accepted at edge N is returned by a display read issued after edge N. A read of the same address in the same cycle returns the old data.
- `pixel` and `pixel_blank` lag `char_x`/`char_y`/`blank` by 2 cycles.
- `char_data` must be presented one cycle after the `char_x`/`char_y` it belongs to, matching the font engine's registered output.
- Reset asserted mid-clear or mid-transfer: all state returns to reset values asynchronously and the clear restarts from address 0. A write in flight is lost.

## Test plan
- Reset release: `busy`=1 for 2048 cycles with both readies 0, then `busy`=0. Every address then reads 0x20 and `pixel`=0 across a full frame.
- A only, writing 0x41 at (0,0) with `b_valid`=0: `a_ready`=1 in the same cycle. Display row bits match the glyph 'A' (row 1 = 01110) in columns 0-4 of char cell (0,0), 2 cycles after the counters.
- A and B both valid for 4 cycles: grants go A, B, A, B. There is never a cycle with both readies high.
- Write at (64,0) then at (0,32): both are handshaked, the buffer is unchanged, and `drop`=1 until reset.
- `clear` pulsed in the same cycle as a B transfer of 0x5A at (3,3): after 2048 cycles (3,3) reads 0x20. A second `clear` at cycle 100 of the clear does not extend it.
- `reset` asserted at clear cycle 500: outputs return to reset values immediately, and the full 2048-cycle clear restarts after release.
